k2_branch_sequencer: RTL

//  Owns the K2 control state around the jump-condition logic:
//  - ZF/CF flag register
//  - S_reg phase FSM
//  - program counter

---
 rtl/k2_pkg.sv | 6 +
 rtl/k2_sat_counter.sv | 15 +
 rtl/k2_branch_sequencer.sv | 72 +++++++
 3 files changed

// File: rtl/k2_pkg.sv
// k2_pkg: shared types and defaults for the K2 branch sequencer
package k2_pkg;
    typedef enum logic {PH_S0, PH_S1} k2_phase_t;
    localparam int K2_PC_W_DEF    = 4;
    localparam int K2_COUNT_W_DEF = 8;
endpackage

// File: rtl/k2_sat_counter.sv
// k2_sat_counter: saturating up-counter with hold and sync active-low reset
module k2_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             hold,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;
    always_comb count_d = (!hold && inc && count_q != '1) ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) count_q <= !reset_n ? '0 : count_d;
    assign count = count_q;
endmodule

// File: rtl/k2_branch_sequencer.sv
// k2_branch_sequencer: flag register, two-phase FSM and PC redirected by jcf
module k2_branch_sequencer
    import k2_pkg::*;
#(
    parameter int PC_W    = K2_PC_W_DEF,
    parameter int COUNT_W = K2_COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               instr_j,
    input  logic               instr_c,
    input  logic [PC_W-1:0]    imm,
    input  logic               flag_we,
    input  logic               zf_in,
    input  logic               cf_in,
    input  logic               jcf,
    output logic               zf,
    output logic               cf,
    output logic               s_reg,
    output logic [PC_W-1:0]    pc,
    output logic               taken,
    output logic               halted,
    output logic [COUNT_W-1:0] jump_count
);
    k2_phase_t       phase_q, phase_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            zf_q, zf_d, cf_q, cf_d, taken_q, taken_d, halted_q, halted_d;
    logic            hold, jump, enter_s1, advance;
    always_comb begin
        hold     = stall || halted_q;
        jump     = !hold && phase_q == PH_S0 && jcf;
        enter_s1 = !hold && phase_q == PH_S0 && !jcf && instr_j && instr_c;
        advance  = !hold && !jump && !enter_s1;
        pc_d     = jump ? imm : advance ? pc_q + 1'b1 : pc_q;
        phase_d  = hold ? phase_q : enter_s1 ? PH_S1 : PH_S0;
        zf_d     = (!hold && flag_we) ? zf_in : zf_q;
        cf_d     = (!hold && flag_we) ? cf_in : cf_q;
        taken_d  = jump;
        halted_d = halted_q || (jump && imm == pc_q);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q  <= PH_S0;
            pc_q     <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            taken_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            taken_q  <= taken_d;
            halted_q <= halted_d;
        end
    end
    k2_sat_counter #(.WIDTH(COUNT_W)) u_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (jump),
        .hold   (hold),
        .count  (jump_count)
    );
    assign zf     = zf_q;
    assign cf     = cf_q;
    assign s_reg  = (phase_q == PH_S1);
    assign pc     = pc_q;
    assign taken  = taken_q;
    assign halted = halted_q;
endmodule
